// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit_serializer codebase slice.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam logic        DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding register between the load handshake and the shifter.
module word_hold_reg
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] pend_data,
  output logic             pend_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A write in the same cycle as a read wins: the slot stays full with the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_data  <= wr_data;
      r_valid <= 1'b1;
    end else if (rd_en) begin
      r_valid <= 1'b0;
    end
  end

  assign pend_data  = r_data;
  assign pend_valid = r_valid;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage feeding the transition detector; back-to-back frames via a one-word hold register.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;

  logic [WIDTH-1:0] w_pend_data;
  logic             w_pend_valid;
  logic             w_last;
  logic             w_consume;
  logic             w_xfer;

  assign w_last    = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);
  assign w_consume = w_pend_valid && ((r_state == IDLE) || w_last);
  // Ready depends only on registered state; reset masks it so nothing is accepted while held in reset.
  assign load_ready = !reset && (!w_pend_valid || w_consume);
  assign w_xfer     = load_valid && load_ready;
  assign busy       = (r_state == SHIFT) || w_pend_valid;

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (w_xfer),
    .wr_data   (load_data),
    .rd_en     (w_consume),
    .pend_data (w_pend_data),
    .pend_valid(w_pend_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ser_out      = IDLE_BIT;
    ser_valid    = 1'b0;
    frame_start  = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_consume) w_next_state = SHIFT;
      end
      SHIFT: begin
        ser_out     = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        ser_valid   = 1'b1;
        frame_start = (r_bit_cnt == '0);
        frame_done  = w_last;
        if (w_last && !w_pend_valid) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_consume) begin
      r_shift   <= w_pend_data;
      r_bit_cnt <= '0;
    end else if (r_state == SHIFT) begin
      if (MSB_FIRST) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus stream, checked against a frame-level model.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_data;
  logic       load_valid;

  logic rdy_m, out_m, val_m, fs_m, fd_m, busy_m;
  logic rdy_l, out_l, val_l, fs_l, fd_l, busy_l;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_m), .ser_out(out_m), .ser_valid(val_m),
    .frame_start(fs_m), .frame_done(fd_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_l), .ser_out(out_l), .ser_valid(val_l),
    .frame_start(fs_l), .frame_done(fd_l), .busy(busy_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per instance, bits left in the current frame, the word being sent, and the pending slot.
  int         rem [2];
  logic [7:0] cur [2];
  bit         pend[2];
  logic [7:0] pw  [2];

  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         xfer_cyc = -1;
  logic       obs_m[$];
  logic       obs_l[$];
  int         vcyc[$];

  task automatic step(input int k, input logic rdy, input logic o, input logic v,
                      input logic fs, input logic fd, input logic b);
    int   bi;
    logic ev, eo, er, cons;
    ev = (rem[k] > 0);
    eo = 1'b0;
    if (ev) begin
      bi = (k == 0) ? rem[k] - 1 : 8 - rem[k];
      eo = cur[k][bi];
    end
    er   = !reset && (!pend[k] || rem[k] <= 1);
    cons = pend[k] && (rem[k] <= 1);
    chk($sformatf("ser_valid[%0d]", k),   v,   ev);
    chk($sformatf("ser_out[%0d]", k),     o,   eo);
    chk($sformatf("frame_start[%0d]", k), fs,  ev && rem[k] == 8);
    chk($sformatf("frame_done[%0d]", k),  fd,  ev && rem[k] == 1);
    chk($sformatf("busy[%0d]", k),        b,   ev || pend[k]);
    chk($sformatf("load_ready[%0d]", k),  rdy, er);
    if (reset) begin
      rem[k]  = 0;
      pend[k] = 1'b0;
    end else begin
      if (rem[k] > 0) rem[k]--;
      if (cons) begin
        cur[k]  = pw[k];
        rem[k]  = 8;
        pend[k] = 1'b0;
      end
      if (load_valid && er) begin
        pend[k] = 1'b1;
        pw[k]   = load_data;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (load_valid && rdy_m === 1'b1 && !reset) xfer_cyc = cyc;
      step(0, rdy_m, out_m, val_m, fs_m, fd_m, busy_m);
      step(1, rdy_l, out_l, val_l, fs_l, fd_l, busy_l);
      if (val_m === 1'b1) begin
        obs_m.push_back(out_m);
        vcyc.push_back(cyc);
      end
      if (val_l === 1'b1) obs_l.push_back(out_l);
    end
  end

  // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [7:0] w);
    bit done;
    done       = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (rdy_m === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (busy_m === 1'b0 && busy_l === 1'b0) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("idle_reached", ok, 1'b1);
  endtask

  task automatic clear_obs();
    obs_m.delete();
    obs_l.delete();
    vcyc.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pk_m, pk_l;
    logic [15:0] p16;
    logic [7:0]  w3[3];
    logic [23:0] p24, e24;
    int          first, trans;
    bit          acc;

    // Sent-order expectations: bit 7 of exp_* is the first bit on ser_out.
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h01, 8'h01, 8'h80};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[3] = '{8'h80, 8'h80, 8'h01};
    vecs[4] = '{8'hC1, 8'hC1, 8'h83};
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; cur[k] = '0; pend[k] = 1'b0; pw[k] = '0;
    end

    reset = 1'b1; load_valid = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_ready", rdy_m, 1'b1);
    chk("post_reset_ser_out", out_m, 1'b0);
    chk("post_reset_busy", busy_m, 1'b0);
    @(posedge clk);
    #1;

    // Single word: latency and frame length.
    clear_obs();
    push(8'hA5);
    wait_idle();
    first = (vcyc.size() > 0) ? vcyc[0] : -100;
    chk("a5_latency", first - xfer_cyc, 2);
    chk("a5_bits", obs_m.size(), 8);
    chk("a5_span", (vcyc.size() == 8) ? vcyc[7] - first : -1, 7);
    chk("a5_idle_out", out_m, 1'b0);

    // Table-driven vectors on both bit orders.
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      push(vecs[i].data);
      wait_idle();
      pk_m = '0; pk_l = '0;
      foreach (obs_m[j]) pk_m = {pk_m[6:0], obs_m[j]};
      foreach (obs_l[j]) pk_l = {pk_l[6:0], obs_l[j]};
      chk($sformatf("vec%0d_msb_count", i), obs_m.size(), 8);
      chk($sformatf("vec%0d_lsb_count", i), obs_l.size(), 8);
      chk($sformatf("vec%0d_msb_bits", i), pk_m, vecs[i].exp_msb);
      chk($sformatf("vec%0d_lsb_bits", i), pk_l, vecs[i].exp_lsb);
    end

    // Back-to-back: 16 contiguous bits.
    clear_obs();
    push(8'hA5);
    push(8'h3C);
    wait_idle();
    p16 = '0;
    foreach (obs_m[j]) p16 = {p16[14:0], obs_m[j]};
    chk("b2b_count", obs_m.size(), 16);
    chk("b2b_bits", p16, 16'hA53C);
    chk("b2b_no_gap", (vcyc.size() == 16) ? vcyc[15] - vcyc[0] : -1, 15);

    // Reset mid-frame with a word pending.
    clear_obs();
    push(8'hFF);
    push(8'h0F);
    for (int n = 0; n < 50 && obs_m.size() < 2; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ser_valid", val_m, 1'b0);
    chk("rst_ser_out", out_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_ready", rdy_m, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_bits_emitted", obs_m.size(), 3);

    // Backpressure: three words with load_valid held throughout.
    clear_obs();
    for (int i = 0; i < 3; i++) w3[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) push(w3[i]);
    wait_idle();
    p24 = '0;
    foreach (obs_m[j]) p24 = {p24[22:0], obs_m[j]};
    e24 = {w3[0], w3[1], w3[2]};
    chk("bp_count", obs_m.size(), 24);
    chk("bp_order", p24, e24);

    // Downstream detector view: 8'h55 toggles on every bit after the first.
    clear_obs();
    push(8'h55);
    wait_idle();
    trans = 0;
    for (int j = 1; j < obs_m.size(); j++) if (obs_m[j] != obs_m[j-1]) trans++;
    chk("det_transitions", trans, 7);

    // Random traffic with occasional resets; every cycle is checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = load_valid && (rdy_m === 1'b1) && !reset;
      @(posedge clk);
      #1;
      if (!load_valid || acc || reset) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = 8'($urandom);
      end
      reset = ($urandom_range(0, 96) == 0);
    end
    load_valid = 1'b0;
    reset      = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the team's transition-detector Mealy FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock.
- ser_out drives the detector's serial input `in`.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- WIDTH, 8, bits per word (2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on ser_out when no frame is shifting.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit to the downstream detector.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse on the first bit of a frame.
- frame_done  output  1  one-cycle pulse on the last bit of a frame.
- busy  output  1  shifting, or a word is held pending.

Behaviour:
- One clock, clk. reset is synchronous and active-high; all registers update on the rising edge of clk only.
- Reset values:
  - state = IDLE; shift register, bit_cnt, pend_valid all 0.
  - ser_out = IDLE_BIT; ser_valid, frame_start, frame_done, busy = 0.
  - load_ready = 0 while reset is high, 1 on the first cycle after release.
- States: IDLE, SHIFT.
- Handshake:
  - Transfer occurs when load_valid && load_ready at a rising edge.
  - load_data is captured into the pending register: pend_valid <= 1.
  - load_ready = !pend_valid || consume. It is a function of registered state only; no combinational path from load_valid.
  - consume = pend_valid && (state == IDLE || (state == SHIFT && bit_cnt == WIDTH-1)).
- Load: on consume, the shift register is loaded from pending, bit_cnt <= 0, state <= SHIFT. pend_valid is cleared unless a new transfer occurs in the same cycle, in which case it stays 1 with the new word.
- Latency: a word accepted at edge T is in pending after T; it is loaded into the shifter at T+1 if idle; its first bit is on ser_out in the cycle after T+1.
- SHIFT:
  - ser_out = shift-register MSB (MSB_FIRST = 1) or LSB (MSB_FIRST = 0), driven combinationally from the register.
  - ser_valid = 1.
  - Each edge, the register shifts toward the output end and bit_cnt increments.
- bit_cnt is $clog2(WIDTH) bits wide.
- frame_start = 1 in SHIFT when bit_cnt == 0. frame_done = 1 in SHIFT when bit_cnt == WIDTH-1.
- On the last bit:
  - If pend_valid, reload immediately: the next word's first bit follows with no gap.
  - Otherwise state <= IDLE.
- IDLE: ser_out = IDLE_BIT, ser_valid = 0.
- busy = (state == SHIFT) || pend_valid.
- Reset mid-frame: the frame is aborted with no partial completion, the pending word is discarded, and all outputs return to reset values on the next edge.
- load_valid while load_ready = 0: no capture; the source must hold load_data stable until transfer.
- Sustained throughput: one word per WIDTH cycles.

Decomposition:
- Shared package/header holds:
  - State encodings as localparams: IDLE = 1'b0, SHIFT = 1'b1.
  - Default WIDTH.
  - IDLE_BIT default.
- One natural sub-module: word_hold_reg.
  - Parameterized WIDTH.
  - Holds pend_data and pend_valid.
  - Inputs: wr_en, rd_en. Supports simultaneous write and read.
- The top level contains the FSM, shift register and counter.

Test Plan:
- Single word, MSB_FIRST = 1: load 8'hA5 accepted at edge T → ser_out = 1,0,1,0,0,1,0,1 over 8 consecutive cycles starting the cycle after T+1; ser_valid high exactly 8 cycles; frame_start on the first bit, frame_done on the eighth; then ser_out = 0, busy = 0.
- Back-to-back: 8'hA5 then 8'h3C with load_valid held high → 16 contiguous valid bits 10100101 00111100; no ser_valid gap; frame_done/frame_start adjacent; load_ready low while pending is full and not being consumed.
- LSB-first: MSB_FIRST = 0, load 8'h01 → ser_out = 1,0,0,0,0,0,0,0.
- Reset mid-frame: load 8'hFF, assert reset for 1 cycle after 3 bits, with 8'h0F pending → next cycle ser_valid = 0, ser_out = 0, busy = 0, load_ready = 1; 8'h0F is never emitted.
- Backpressure: hold load_valid for 3 words with a full pending register → words 2 and 3 are accepted only when load_ready = 1; no word is lost or duplicated; output order matches input order.
- System check with the downstream detector: stream 8'h55 → detector out pulses 1 on each of the 7 bit-to-bit transitions after the first bit.
